// File: rtl/axi4_led_sched_pkg.sv
// Shared types and defaults for the AXI-activity LED blink-code scheduler.
// The counter width helper keeps the cycle counter just wide enough for the longest phase.
package axi4_led_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int DEF_N_SLOTS    = 3;
  localparam int DEF_ON_CYCLES  = 12_500_000;
  localparam int DEF_OFF_CYCLES = 12_500_000;
  localparam int DEF_GAP_CYCLES = 50_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/axi4_led_blink_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping modulo N. The one-hot grant is only driven when 'valid' is high.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    w_found   = 1'b0;
    w_j       = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(last) + k) % N);
      if (!w_found && req[w_j]) begin
        w_found   = 1'b1;
        grant_idx = w_j;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (valid && w_found && (IW'(i) == grant_idx)) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/axi4_led_blink_sched.sv
// Shares one LED between N AXI slots: each address handshake marks its slot pending,
// and a round-robin scheduler blinks slot i's code (i+1 pulses, then a gap).
module axi4_led_blink_sched
  import axi4_led_sched_pkg::*;
#(
  parameter int N_SLOTS    = DEF_N_SLOTS,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [N_SLOTS-1:0] axi_arvalid,
  input  logic [N_SLOTS-1:0] axi_arready,
  input  logic [N_SLOTS-1:0] axi_awvalid,
  input  logic [N_SLOTS-1:0] axi_awready,
  output logic               LED,
  output logic               busy,
  output logic [SW-1:0]      cur_slot,
  output logic [N_SLOTS-1:0] pending
);

  localparam int CW = $clog2(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES)) + 1;
  localparam int BW = $clog2(N_SLOTS + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [BW-1:0]      r_blinks, w_blinks_nxt;
  logic [SW-1:0]      r_cur, w_cur_nxt;
  logic [SW-1:0]      r_last, w_last_nxt;
  logic [N_SLOTS-1:0] r_pending, w_pending_nxt;
  logic               r_led;

  logic [N_SLOTS-1:0] w_act;
  logic [N_SLOTS-1:0] w_grant;
  logic [SW-1:0]      w_gidx;
  logic               w_any_req;
  logic               w_arb_valid;

  assign w_act       = (axi_arvalid & axi_arready) | (axi_awvalid & axi_awready);
  assign w_arb_valid = en && (r_state == S_IDLE);

  rr_arbiter #(.N(N_SLOTS)) u_arb (
    .req       (r_pending),
    .last      (r_last),
    .valid     (w_arb_valid),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any_req   (w_any_req)
  );

  // A same-edge handshake re-arms a slot that is being granted (set wins).
  assign w_pending_nxt = en ? ((r_pending & ~w_grant) | w_act) : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_blinks_nxt = r_blinks;
    w_cur_nxt    = r_cur;
    w_last_nxt   = r_last;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (|w_grant) begin
          w_state_nxt  = S_ON;
          w_cur_nxt    = w_gidx;
          w_last_nxt   = w_gidx;
          w_blinks_nxt = BW'(w_gidx) + BW'(1);
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt  = S_OFF;
          w_cnt_nxt    = '0;
          w_blinks_nxt = r_blinks - BW'(1);
        end
      end
      S_OFF: begin
        if (r_cnt == OFF_LAST) begin
          w_state_nxt = (r_blinks != '0) ? S_ON : S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_blinks  <= '0;
      r_cur     <= '0;
      r_last    <= SW'(N_SLOTS - 1);
      r_pending <= '0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_blinks  <= w_blinks_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_pending <= w_pending_nxt;
      r_led     <= (w_state_nxt == S_ON);
    end
  end

  assign LED      = r_led;
  assign busy     = (r_state != S_IDLE);
  assign cur_slot = r_cur;
  assign pending  = r_pending;

endmodule
